// File: rtl/mem_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_n
//  Purpose  : Byte-serial RAM controller that arbitrates NCH request channels
//             onto one single-port RAM with one-cycle read latency. Each
//             channel has a one-deep request slot, a busy flag and a discard
//             input. Priority is fixed (highest index) or round-robin.
//  Ports    : clk, rst (sync, active-low)
//             req_en/req_rw/req_addr/req_len/req_wdata : per-channel request
//             discard   : cancel pending or active request of a channel
//             busy/done : per-channel status / one-cycle completion pulse
//             rdata     : load result, valid while done is high
//             ram_rw/ram_addr/ram_wdata/ram_rdata : RAM side
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter_n #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RAM_W  = 8,
    parameter int RR     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_en,
    input  logic [NCH-1:0]        req_rw,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*3-1:0]      req_len,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    input  logic [NCH-1:0]        discard,
    output logic [NCH-1:0]        busy,
    output logic [NCH-1:0]        done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ram_rw,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [RAM_W-1:0]      ram_wdata,
    input  logic [RAM_W-1:0]      ram_rdata
);

    localparam int c_bytes = DATA_W / RAM_W;
    localparam int c_lw    = 4;
    localparam int c_chw   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    // Per-channel one-deep request slots
    logic [NCH-1:0]    r_pend;
    logic [NCH-1:0]    r_busy;
    logic [NCH-1:0]    r_slot_rw;
    logic [ADDR_W-1:0] r_slot_addr  [NCH];
    logic [c_lw-1:0]   r_slot_len   [NCH];
    logic [DATA_W-1:0] r_slot_wdata [NCH];

    // Active transfer
    logic [c_chw-1:0]  r_act;
    logic [c_chw-1:0]  r_last;
    logic              r_rw;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [c_lw-1:0]   r_len;
    logic [c_lw-1:0]   r_s;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rbuf;
    logic [DATA_W-1:0] r_rdata;
    logic [NCH-1:0]    r_done;

    // Unpacked request inputs
    logic [ADDR_W-1:0] w_in_addr  [NCH];
    logic [c_lw-1:0]   w_in_len   [NCH];
    logic [DATA_W-1:0] w_in_wdata [NCH];

    logic [NCH-1:0]    w_acc, w_elig, w_pend_nxt, w_busy_nxt;
    logic              w_final, w_abort, w_grant, w_found;
    logic [c_chw-1:0]  w_gnt;
    logic              w_g_rw;
    logic [ADDR_W-1:0] w_g_addr;
    logic [c_lw-1:0]   w_g_len;
    logic [DATA_W-1:0] w_g_wdata;
    logic [RAM_W-1:0]  w_wbyte;
    logic [DATA_W-1:0] w_rbuf_upd;

    // Length 0 behaves as 1; anything above the word size is clamped.
    function automatic logic [c_lw-1:0] norm_len(input logic [2:0] l);
        if (l == 3'd0)
            return c_lw'(1);
        else if (int'(l) > c_bytes)
            return c_lw'(c_bytes);
        else
            return c_lw'(l);
    endfunction

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_in_addr[c]  = req_addr[c*ADDR_W +: ADDR_W];
            w_in_len[c]   = norm_len(req_len[c*3 +: 3]);
            w_in_wdata[c] = req_wdata[c*DATA_W +: DATA_W];
        end
    end

    // Eligibility, grant decision and slot bookkeeping
    always_comb begin
        w_acc   = req_en & ~r_busy & ~discard;
        w_elig  = (r_pend & ~discard) | w_acc;
        w_final = (r_state == XFER) &&
                  (r_s == (r_rw ? r_len - c_lw'(1) : r_len));
        w_abort = (r_state == XFER) && discard[r_act];
        w_grant = (|w_elig) && ((r_state == IDLE) || w_final || w_abort);

        w_gnt   = '0;
        w_found = 1'b0;
        if (RR != 0) begin
            // Search starts one past the previous grant
            for (int k = 0; k < NCH; k++) begin
                if (!w_found && w_elig[(int'(r_last) + 1 + k) % NCH]) begin
                    w_gnt   = c_chw'((int'(r_last) + 1 + k) % NCH);
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_elig[c])
                    w_gnt = c_chw'(c);
            end
        end

        // A channel granted the same cycle it is accepted has no slot yet
        w_g_rw    = r_pend[w_gnt] ? r_slot_rw[w_gnt]    : req_rw[w_gnt];
        w_g_addr  = r_pend[w_gnt] ? r_slot_addr[w_gnt]  : w_in_addr[w_gnt];
        w_g_len   = r_pend[w_gnt] ? r_slot_len[w_gnt]   : w_in_len[w_gnt];
        w_g_wdata = r_pend[w_gnt] ? r_slot_wdata[w_gnt] : w_in_wdata[w_gnt];

        w_pend_nxt = (r_pend & ~discard) | w_acc;
        w_busy_nxt = (r_busy & ~(r_pend & discard)) | w_acc;
        if (w_final || w_abort)
            w_busy_nxt[r_act] = 1'b0;
        if (w_grant)
            w_pend_nxt[w_gnt] = 1'b0;
    end

    // Byte lanes: write byte for stage s, read byte s-1 merged into buffer
    always_comb begin
        w_wbyte    = '0;
        w_rbuf_upd = r_rbuf;
        for (int b = 0; b < c_bytes; b++) begin
            if (r_s == c_lw'(b))
                w_wbyte = r_wdata[RAM_W*b +: RAM_W];
            if (r_s == c_lw'(b + 1))
                w_rbuf_upd[RAM_W*b +: RAM_W] = ram_rdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant)
            w_state_nxt = XFER;
        else if (w_final || w_abort)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend      <= '0;
            r_busy      <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_addr_hold <= '0;
            r_act       <= '0;
            r_last      <= c_chw'(NCH - 1);
            r_rw        <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_s         <= '0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
        end else begin
            r_done <= '0;
            r_pend <= w_pend_nxt;
            r_busy <= w_busy_nxt;
            for (int c = 0; c < NCH; c++) begin
                if (w_acc[c]) begin
                    r_slot_rw[c]    <= req_rw[c];
                    r_slot_addr[c]  <= w_in_addr[c];
                    r_slot_len[c]   <= w_in_len[c];
                    r_slot_wdata[c] <= w_in_wdata[c];
                end
            end
            if (r_state == XFER) begin
                r_addr_hold <= ram_addr;
                r_s         <= r_s + c_lw'(1);
                if (!r_rw)
                    r_rbuf <= w_rbuf_upd;
                if (w_final && !w_abort) begin
                    r_done[r_act] <= 1'b1;
                    if (!r_rw)
                        r_rdata <= w_rbuf_upd;
                end
            end
            if (w_grant) begin
                r_act   <= w_gnt;
                r_last  <= w_gnt;
                r_rw    <= w_g_rw;
                r_base  <= w_g_addr;
                r_len   <= w_g_len;
                r_wdata <= w_g_wdata;
                r_s     <= '0;
                r_rbuf  <= '0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign ram_rw    = (r_state == XFER) && r_rw;
    assign ram_addr  = (r_state == XFER) ? r_base + ADDR_W'(r_s) : r_addr_hold;
    assign ram_wdata = ((r_state == XFER) && r_rw) ? w_wbyte : '0;

endmodule
`default_nettype wire
